// File: rtl/awg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : awg_pkg
// Description : Shared field encodings, value limits and reset defaults for
//               the arbitrary-waveform-generator control and generator blocks,
//               plus saturating step helpers for the frequency and amplitude.
// Revision    : 1.0 - initial release
// ============================================================================
package awg_pkg;

    // Selected-field encoding (2'd3 is unused)
    localparam logic [1:0]  FLD_FREQ  = 2'd0;
    localparam logic [1:0]  FLD_AMP   = 2'd1;
    localparam logic [1:0]  FLD_PHASE = 2'd2;

    // Legal value ranges; zero is excluded because the generator divides by amp
    // and a zero phase step would freeze the accumulator
    localparam logic [11:0] FREQ_MIN  = 12'd1;
    localparam logic [11:0] FREQ_MAX  = 12'd4095;
    localparam logic [2:0]  AMP_MIN   = 3'd1;
    localparam logic [2:0]  AMP_MAX   = 3'd7;

    // Reset defaults
    localparam logic        RST_EN    = 1'b0;
    localparam logic [11:0] RST_FREQ  = 12'd64;
    localparam logic [2:0]  RST_AMP   = 3'd1;
    localparam logic [7:0]  RST_PHASE = 8'd0;
    localparam logic [1:0]  RST_SEL   = FLD_FREQ;

    // Frequency step up, clamped at FREQ_MAX
    function automatic logic [11:0] freq_inc(input logic [11:0] f, input logic [11:0] step);
        logic [12:0] s;
        s = {1'b0, f} + {1'b0, step};
        return (s > {1'b0, FREQ_MAX}) ? FREQ_MAX : s[11:0];
    endfunction

    // Frequency step down, clamped at FREQ_MIN (f > step guarantees f - step >= 1)
    function automatic logic [11:0] freq_dec(input logic [11:0] f, input logic [11:0] step);
        return (f > step) ? (f - step) : FREQ_MIN;
    endfunction

    // Amplitude +1, clamped at AMP_MAX
    function automatic logic [2:0] amp_inc(input logic [2:0] a);
        return (a >= AMP_MAX) ? AMP_MAX : (a + 3'd1);
    endfunction

    // Amplitude -1, clamped at AMP_MIN
    function automatic logic [2:0] amp_dec(input logic [2:0] a);
        return (a <= AMP_MIN) ? AMP_MIN : (a - 3'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One raw push-button path: two-flop synchronizer, debounce
//               qualifier (level accepted after DEB_CNT consecutive identical
//               samples), and a one-cycle event on the debounced rising edge.
//               With AWG_CTRL_AUTOREPEAT_EN defined and REPEAT_EN set, a held
//               button also emits a repeat event HOLD_CNT cycles after the press
//               and then every REP_CNT cycles until release.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter logic [19:0] DEB_CNT   = 20'd1000000,
    parameter bit          REPEAT_EN = 1'b0,
    parameter logic [23:0] HOLD_CNT  = 24'd25000000,
    parameter logic [23:0] REP_CNT   = 24'd5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_event
);

    logic [1:0]  r_sync;
    logic [19:0] r_cnt;
    logic        r_level;
    logic        r_press;

    logic        w_sample;
    logic        w_accept;
    logic        w_level_nxt;

    assign w_sample    = r_sync[1];
    // The DEB_CNT-th consecutive sample that disagrees with the current level
    assign w_accept    = (w_sample != r_level) && (r_cnt == (DEB_CNT - 20'd1));
    assign w_level_nxt = w_accept ? w_sample : r_level;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Debounce counter, qualified level and rising-edge press pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            if ((w_sample == r_level) || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
            r_level <= w_level_nxt;
            r_press <= w_accept & w_sample;
        end
    end

`ifdef AWG_CTRL_AUTOREPEAT_EN
    logic [23:0] r_rcnt;
    logic        r_rphase;
    logic        r_rep;

    // Auto-repeat timer: first repeat HOLD_CNT cycles after the press, then every
    // REP_CNT cycles; cleared on the press cycle itself and whenever the level drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt   <= '0;
            r_rphase <= 1'b0;
            r_rep    <= 1'b0;
        end else begin
            r_rep <= 1'b0;
            if (!REPEAT_EN || !r_level || !w_level_nxt) begin
                r_rcnt   <= '0;
                r_rphase <= 1'b0;
            end else if (r_rcnt == ((r_rphase ? REP_CNT : HOLD_CNT) - 24'd1)) begin
                r_rcnt   <= '0;
                r_rphase <= 1'b1;
                r_rep    <= 1'b1;
            end else begin
                r_rcnt <= r_rcnt + 24'd1;
            end
        end
    end

    assign o_event = r_press | r_rep;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{REPEAT_EN, HOLD_CNT, REP_CNT};
    assign o_event      = r_press;
`endif

endmodule
`default_nettype wire

// File: rtl/awg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : awg_ctrl
// Description : Front-panel controller for the waveform generator. Four
//               debounced buttons select a field (FREQ/AMP/PHASE), step it up
//               or down with saturation (phase wraps), and toggle the output
//               enable. update pulses for one cycle whenever en or a state_*
//               value actually changes.
//               Optional feature macro: AWG_CTRL_AUTOREPEAT_EN (hold-to-repeat
//               on the up/down buttons).
// Revision    : 1.0 - initial release
// ============================================================================
module awg_ctrl
    import awg_pkg::*;
#(
    parameter logic [19:0] DEB_CNT   = 20'd1000000,
    parameter logic [11:0] FREQ_STEP = 12'd16,
    parameter logic [23:0] HOLD_CNT  = 24'd25000000,
    parameter logic [23:0] REP_CNT   = 24'd5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_sel,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_en,
    output logic        en,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  sel,
    output logic        update
);

    // Button index order: 0 sel, 1 up, 2 down, 3 en
    logic [3:0]  w_raw;
    logic [3:0]  w_ev;

    logic        w_ev_sel;
    logic        w_ev_up;
    logic        w_ev_down;
    logic        w_ev_en;
    logic        w_val_ev;
    logic        w_val_chg;

    logic        w_en_nxt;
    logic [1:0]  w_sel_nxt;
    logic [11:0] w_freq_nxt;
    logic [2:0]  w_amp_nxt;
    logic [7:0]  w_phase_nxt;

    logic        r_en;
    logic [1:0]  r_sel;
    logic [11:0] r_freq;
    logic [2:0]  r_amp;
    logic [7:0]  r_phase;
    logic        r_update;

    assign w_raw = {btn_en, btn_down, btn_up, btn_sel};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            btn_debounce #(
                .DEB_CNT   (DEB_CNT),
                .REPEAT_EN ((i == 1) || (i == 2)),
                .HOLD_CNT  (HOLD_CNT),
                .REP_CNT   (REP_CNT)
            ) u_btn (
                .clk     (clk),
                .rst     (rst),
                .i_btn   (w_raw[i]),
                .o_event (w_ev[i])
            );
        end
    endgenerate

    assign w_ev_sel  = w_ev[0];
    assign w_ev_up   = w_ev[1];
    assign w_ev_down = w_ev[2];
    assign w_ev_en   = w_ev[3];

    // A value step needs exactly one of up/down and no concurrent field change
    assign w_val_ev  = ~w_ev_sel & (w_ev_up ^ w_ev_down);

    // Next-state computation for the field selector and the three values
    always_comb begin
        w_en_nxt    = r_en ^ w_ev_en;
        w_sel_nxt   = r_sel;
        w_freq_nxt  = r_freq;
        w_amp_nxt   = r_amp;
        w_phase_nxt = r_phase;

        if (w_ev_sel) begin
            case (r_sel)
                FLD_FREQ: w_sel_nxt = FLD_AMP;
                FLD_AMP:  w_sel_nxt = FLD_PHASE;
                default:  w_sel_nxt = FLD_FREQ;
            endcase
        end else if (r_sel == 2'd3) begin
            w_sel_nxt = FLD_FREQ;
        end

        if (w_val_ev) begin
            case (r_sel)
                FLD_FREQ:  w_freq_nxt  = w_ev_up ? freq_inc(r_freq, FREQ_STEP)
                                                 : freq_dec(r_freq, FREQ_STEP);
                FLD_AMP:   w_amp_nxt   = w_ev_up ? amp_inc(r_amp) : amp_dec(r_amp);
                FLD_PHASE: w_phase_nxt = w_ev_up ? (r_phase + 8'd1) : (r_phase - 8'd1);
                default:   ;
            endcase
        end

        w_val_chg = (w_freq_nxt != r_freq) || (w_amp_nxt != r_amp) ||
                    (w_phase_nxt != r_phase);
    end

    // Field-select FSM and registered outputs; update flags a real value change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= RST_EN;
            r_sel    <= RST_SEL;
            r_freq   <= RST_FREQ;
            r_amp    <= RST_AMP;
            r_phase  <= RST_PHASE;
            r_update <= 1'b0;
        end else begin
            r_en     <= w_en_nxt;
            r_sel    <= w_sel_nxt;
            r_freq   <= w_freq_nxt;
            r_amp    <= w_amp_nxt;
            r_phase  <= w_phase_nxt;
            r_update <= w_ev_en | w_val_chg;
        end
    end

    assign en          = r_en;
    assign sel         = r_sel;
    assign state_freq  = r_freq;
    assign state_amp   = r_amp;
    assign state_phase = r_phase;
    assign update      = r_update;

endmodule
`default_nettype wire
